// File: rtl/montgomery_mul_serial_if.sv
// Operand/result handshake between the RSA control wrapper and the
// serial Montgomery multiplier.
interface montgomery_mul_serial_if #(
   parameter int WIDTH = 1024
);
   logic             start;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_m;
   logic [WIDTH-1:0] result;
   logic             done;

   modport master (
      output start, in_a, in_b, in_m,
      input  result, done
   );

   modport slave (
      input  start, in_a, in_b, in_m,
      output result, done
   );
endinterface

// File: rtl/montgomery_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M,
// one bit of A consumed per cycle, WIDTH+2 cycles from start to done.
module montgomery_mul_serial #(
   parameter int WIDTH = 1024
) (
   input  logic                   clk,
   input  logic                   resetn,
   montgomery_mul_serial_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, PRECOMP, LOOP, FINAL} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, m_reg, result_reg;
   logic [WIDTH:0]   bm_reg;
   logic [WIDTH+1:0] c_reg, operand, sum;
   logic [WIDTH-1:0] c_minus_m;
   logic [CW-1:0]    cnt_reg;
   logic             done_reg;
   logic             a_bit, q_bit, last_iter;

   // A is shifted right each iteration so bit 0 always holds A[i].
   assign a_bit     = a_reg[0];
   assign q_bit     = c_reg[0] ^ (a_bit & b_reg[0]);
   assign last_iter = (cnt_reg == CW'(WIDTH - 1));
   assign sum       = c_reg + operand;
   // C < 2M in FINAL, so C - M fits in WIDTH bits whenever it is selected.
   assign c_minus_m = c_reg[WIDTH-1:0] - m_reg;

   assign bus.result = result_reg;
   assign bus.done   = done_reg;

   always_comb begin
      operand = '0;
      case ({a_bit, q_bit})
         2'b11:   operand = {1'b0, bm_reg};
         2'b10:   operand = {2'b00, b_reg};
         2'b01:   operand = {2'b00, m_reg};
         default: operand = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = PRECOMP;
         PRECOMP: state_next = LOOP;
         LOOP:    if (last_iter) state_next = FINAL;
         FINAL:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_reg      <= '0;
         b_reg      <= '0;
         m_reg      <= '0;
         bm_reg     <= '0;
         c_reg      <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_reg   <= bus.in_a;
                  b_reg   <= bus.in_b;
                  m_reg   <= bus.in_m;
                  c_reg   <= '0;
                  cnt_reg <= '0;
               end
            end
            PRECOMP: begin
               bm_reg <= {1'b0, b_reg} + {1'b0, m_reg};
            end
            LOOP: begin
               c_reg   <= sum >> 1;
               a_reg   <= a_reg >> 1;
               cnt_reg <= cnt_reg + CW'(1);
            end
            FINAL: begin
               result_reg <= (c_reg >= {2'b00, m_reg}) ? c_minus_m : c_reg[WIDTH-1:0];
               done_reg   <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/montgomery_mul_serial.md
Name: montgomery_mul_serial

Overview:
- Bit-serial radix-2 Montgomery multiplier.
- Computes result = in_a · in_b · 2^-WIDTH mod in_m.
- Sits directly downstream of the RSA control/DMA wrapper, which drives the operands and a start pulse while in its COMPUTE state, then waits for done before returning the result over DMA.
- Datapath: one WIDTH+2-bit adder per cycle; one iteration per bit of in_a.

Parameters:
- WIDTH, 1024: operand/modulus width in bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  start request; sampled only in IDLE. A single-cycle pulse is sufficient.
- in_a  input  WIDTH  multiplicand A; requires A < M.
- in_b  input  WIDTH  multiplier B; requires B < M.
- in_m  input  WIDTH  modulus M; must be odd.
- result  output  WIDTH  A·B·2^-WIDTH mod M, fully reduced (< M).
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Reset:
  - resetn low asynchronously forces state=IDLE, result=0, done=0.
  - Accumulator, counter and operand latches clear to 0.
  - Reset mid-operation aborts the computation; no done pulse follows.
- States: IDLE -> PRECOMP -> LOOP -> FINAL -> IDLE.
- IDLE:
  - On start=1 at an edge, latch in_a, in_b, in_m into internal registers; clear accumulator C (WIDTH+2 bits) and iteration counter i.
  - Go to PRECOMP.
  - Inputs are not sampled again until the next start.
- PRECOMP (1 cycle): BM <= B + M, WIDTH+1 bits. Go to LOOP.
- LOOP (exactly WIDTH cycles, i = 0..WIDTH-1), each cycle:
  - a_i = A[i].
  - q = C[0] XOR (a_i AND B[0]).
  - operand = a_i ? (q ? BM : B) : (q ? M : 0), zero-extended to WIDTH+2 bits.
  - C <= (C + operand) >> 1.
  - Invariant: C < 2M after every iteration. The WIDTH+2-bit sum cannot overflow.
  - After i = WIDTH-1, go to FINAL.
- FINAL (1 cycle):
  - result <= (C >= M) ? C - M : C[WIDTH-1:0].
  - done <= 1 for exactly this one cycle.
  - Go to IDLE.
- Latency: start sampled at edge k -> result and done registered at edge k+WIDTH+2.
  - done is high for the cycle after that edge.
  - WIDTH=1024 gives 1026 cycles.
- result holds its value after done falls, until the next FINAL or reset.
  - result does NOT change at start, because the wrapper reads result during TX after done.
- start while busy (PRECOMP/LOOP/FINAL) is ignored: no restart, no queuing.
- start asserted in the same cycle done is high: done is registered in FINAL, so the machine is back in IDLE on the following edge and accepts a start held there.
- Input changes after the start edge have no effect on the running computation.
- Illegal operands (M even, A ≥ M or B ≥ M):
  - result is unspecified, but latency and done behaviour are unchanged.
  - No hang is permitted.
- Special operand values:
  - A=0 or B=0 yields 0.
  - M=1 yields 0.
- Edge cases needing no special handling:
  - Counter wrap: the counter is ceil(log2(WIDTH)) bits and never wraps mid-loop.
  - The terminal count is detected as i == WIDTH-1.

Test Plan:
- WIDTH=8: A=5, B=7, M=13 -> result=1, done high exactly 10 cycles after the start edge, one cycle wide.
- WIDTH=8: A=12, B=12, M=13 -> result=3. Then A=0, B=9, M=13 -> result=0. Back-to-back starts issued the cycle after done; each done pulse appears at 10 cycles.
- WIDTH=1024: A=1, B=1, M=2^1024-1 -> result=1 (R≡1 mod M), done at cycle 1026. Also check 100 random odd M with A, B < M against a reference model of A·B·R^-1 mod M.
- WIDTH=8, A=5, B=7, M=13: pulse start again and change in_a/in_b/in_m at cycles 3 and 5 of LOOP -> result still 1, done at cycle 10, no second done.
- WIDTH=8: assert resetn=0 asynchronously mid-LOOP -> state=IDLE, done=0, result=0 immediately. No done afterward until a new start, which then completes normally in 10 cycles.
- Hold state with start=0 for 50 cycles after a completed run -> result stays at the last value, done stays 0.
